gcd_engine: RTL and testbench

Parametrised greatest-common-divisor unit: a fused controller and datapath that accepts an operand pair over a valid/ready handshake, computes GCD by repeated subtraction, and returns the result over a second valid/ready handshake. It is the next generation of the lab GCD datapath. It adds width generalisation, zero-operand handling, a built-in FSM and output back-pressure, so it drops into larger designs without an external controller.

---
 rtl/gcd_pkg.sv | 26 ++
 rtl/gcd_datapath.sv | 76 +++++++
 rtl/gcd_engine.sv | 157 +++++++++++++++
 tb/tb_gcd_engine.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared constants and types for the GCD engine.
//   - FSM state encoding (ST_IDLE / ST_CALC / ST_DONE) and the matching enum
//   - default operand width and iteration-counter width
//   - operand load-mux select encoding used between engine and datapath
package gcd_pkg;

   localparam int unsigned GCD_WIDTH_DEF  = 8;
   localparam int unsigned GCD_ITER_W_DEF = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StCalc = ST_CALC,
      StDone = ST_DONE
   } state_e;

   // Source for an operand register when it is loaded.
   typedef enum logic {
      SelLoad = 1'b0,  // capture the external operand
      SelSub  = 1'b1   // take the difference (larger minus smaller)
   } sel_e;

endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: operand registers, subtractors, comparator and result register.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   x_in_i, y_in_i          external operands
//   x_ld_i, y_ld_i          load enables for the x / y registers
//   x_sel_i, y_sel_i        load source: external operand or difference
//   d_o_ld_i                capture x|y into the result register
//   x_lt_y_o, x_eq_y_o      unsigned comparison of the current x and y
//   any_zero_o              x or y is zero
//   d_o                     registered result
module gcd_datapath
   import gcd_pkg::*;
#(
   parameter int unsigned WIDTH = GCD_WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] x_in_i,
   input  logic [WIDTH-1:0] y_in_i,
   input  logic             x_ld_i,
   input  logic             y_ld_i,
   input  sel_e             x_sel_i,
   input  sel_e             y_sel_i,
   input  logic             d_o_ld_i,
   output logic             x_lt_y_o,
   output logic             x_eq_y_o,
   output logic             any_zero_o,
   output logic [WIDTH-1:0] d_o
);

   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] x_minus_y;
   logic [WIDTH-1:0] y_minus_x;

   // The controller only selects the difference whose minuend is the larger
   // operand, so neither subtractor result is ever used after an underflow.
   assign x_minus_y = x_q - y_q;
   assign y_minus_x = y_q - x_q;

   assign x_lt_y_o   = x_q < y_q;
   assign x_eq_y_o   = x_q == y_q;
   assign any_zero_o = (x_q == '0) || (y_q == '0);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      d_d = d_q;
      if (x_ld_i) begin
         x_d = (x_sel_i == SelSub) ? x_minus_y : x_in_i;
      end
      if (y_ld_i) begin
         y_d = (y_sel_i == SelSub) ? y_minus_x : y_in_i;
      end
      // x|y covers gcd(a,0)=a, gcd(0,b)=b, gcd(0,0)=0 and x==y in one term.
      if (d_o_ld_i) begin
         d_d = x_q | y_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q <= '0;
         y_q <= '0;
         d_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         d_q <= d_d;
      end
   end

   assign d_o = d_q;

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: GCD by repeated subtraction with valid/ready input and output.
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake; in_ready is high only in IDLE
//   x_i, y_i                unsigned operands
//   out_valid / out_ready   result handshake; d_o held while out_valid
//   d_o                     registered GCD result, kept until the next job
//   iter_o                  CALC-cycle count of the last job (GCD_ITER_COUNT_EN)
// Build option: define GCD_ITER_COUNT_EN to add the saturating iteration
// counter and the iter_o port.
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int unsigned WIDTH  = GCD_WIDTH_DEF,
   parameter int unsigned ITER_W = GCD_ITER_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  x_i,
   input  logic [WIDTH-1:0]  y_i,
   output logic              out_valid,
   input  logic              out_ready,
`ifdef GCD_ITER_COUNT_EN
   output logic [ITER_W-1:0] iter_o,
`endif
   output logic [WIDTH-1:0]  d_o
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("gcd_engine: WIDTH must be in 2..32");
   end
   if (ITER_W < 1) begin : g_bad_iter_w
      $error("gcd_engine: ITER_W must be at least 1");
   end

   state_e state_q, state_d;
   logic   in_ready_q, in_ready_d;
   logic   out_valid_q, out_valid_d;

   logic x_ld, y_ld, d_o_ld;
   sel_e x_sel, y_sel;
   logic x_lt_y, x_eq_y, any_zero;
   logic accept;

   assign accept = (state_q == StIdle) && in_valid;

   always_comb begin
      state_d = state_q;
      x_ld    = 1'b0;
      y_ld    = 1'b0;
      x_sel   = SelLoad;
      y_sel   = SelLoad;
      d_o_ld  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               x_ld    = 1'b1;
               y_ld    = 1'b1;
               state_d = StCalc;
            end
         end
         StCalc: begin
            if (any_zero || x_eq_y) begin
               d_o_ld  = 1'b1;
               state_d = StDone;
            end else if (x_lt_y) begin
               y_ld  = 1'b1;
               y_sel = SelSub;
            end else begin
               x_ld  = 1'b1;
               x_sel = SelSub;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // Handshake outputs are registered decodes of the next state.
      in_ready_d  = (state_d == StIdle);
      out_valid_d = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;

   gcd_datapath #(
      .WIDTH(WIDTH)
   ) u_datapath (
      .clk_i      (clk),
      .rst_ni     (reset),
      .x_in_i     (x_i),
      .y_in_i     (y_i),
      .x_ld_i     (x_ld),
      .y_ld_i     (y_ld),
      .x_sel_i    (x_sel),
      .y_sel_i    (y_sel),
      .d_o_ld_i   (d_o_ld),
      .x_lt_y_o   (x_lt_y),
      .x_eq_y_o   (x_eq_y),
      .any_zero_o (any_zero),
      .d_o        (d_o)
   );

`ifdef GCD_ITER_COUNT_EN
   logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [ITER_W-1:0] iter_cnt_inc;

   // Saturating increment: the count sticks at all-ones.
   assign iter_cnt_inc = (iter_cnt_q == {ITER_W{1'b1}}) ? iter_cnt_q
                                                        : iter_cnt_q + ITER_W'(1);

   always_comb begin
      iter_cnt_d = iter_cnt_q;
      iter_d     = iter_q;
      if (accept) begin
         iter_cnt_d = '0;
      end else if (state_q == StCalc) begin
         iter_cnt_d = iter_cnt_inc;
      end
      // The final compare cycle is counted, so publish the incremented value.
      if (d_o_ld) begin
         iter_d = iter_cnt_inc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         iter_cnt_q <= '0;
         iter_q     <= '0;
      end else begin
         iter_cnt_q <= iter_cnt_d;
         iter_q     <= iter_d;
      end
   end

   assign iter_o = iter_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed scoreboard bench for gcd_engine at WIDTH=8 and 16.
module tb_gcd_engine;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic        iv8 = 1'b0, or8 = 1'b1;
   logic        ir8, ov8;
   logic [7:0]  x8 = '0, y8 = '0, d8;
   // WIDTH=16 instance
   logic        iv16 = 1'b0, or16 = 1'b1;
   logic        ir16, ov16;
   logic [15:0] x16 = '0, y16 = '0, d16;
`ifdef GCD_ITER_COUNT_EN
   logic [15:0] it8, it16;
`endif

   gcd_engine #(.WIDTH(8), .ITER_W(16)) u_dut8 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (iv8),
      .in_ready  (ir8),
      .x_i       (x8),
      .y_i       (y8),
      .out_valid (ov8),
      .out_ready (or8),
`ifdef GCD_ITER_COUNT_EN
      .iter_o    (it8),
`endif
      .d_o       (d8)
   );

   gcd_engine #(.WIDTH(16), .ITER_W(16)) u_dut16 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (iv16),
      .in_ready  (ir16),
      .x_i       (x16),
      .y_i       (y16),
      .out_valid (ov16),
      .out_ready (or16),
`ifdef GCD_ITER_COUNT_EN
      .iter_o    (it16),
`endif
      .d_o       (d16)
   );

   typedef struct {
      logic [15:0] d;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: result and number of subtraction steps by definition.
   function automatic void model(input logic [15:0] a_in, input logic [15:0] b_in,
                                 output logic [15:0] g, output int s);
      logic [15:0] a, b;
      a = a_in;
      b = b_in;
      s = 0;
      while (!(a == 0 || b == 0 || a == b)) begin
         if (a < b) b = b - a;
         else       a = a - b;
         s++;
      end
      g = a | b;
   endfunction

   function automatic logic cur_ov(input bit wide);
      return wide ? ov16 : ov8;
   endfunction
   function automatic logic cur_ir(input bit wide);
      return wide ? ir16 : ir8;
   endfunction
   function automatic logic [15:0] cur_d(input bit wide);
      return wide ? d16 : {8'h00, d8};
   endfunction

   // Drive one job, wait (bounded) for out_valid, then pop and compare.
   task automatic run_job(input string tag, input bit wide,
                          input logic [15:0] a, input logic [15:0] b);
      logic [15:0] g;
      int          s, n;
      exp_t        e;
      model(a, b, g, s);
      sb.push_back('{d: g, lat: s + 1});
      @(negedge clk);
      check({tag, ".in_ready_idle"}, 32'(cur_ir(wide)), 32'd1);
      if (wide) begin
         iv16 = 1'b1; x16 = a; y16 = b;
      end else begin
         iv8 = 1'b1; x8 = a[7:0]; y8 = b[7:0];
      end
      @(posedge clk);
      #1;
      iv8 = 1'b0;
      iv16 = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!cur_ov(wide) && n < 2000);
      check({tag, ".out_valid"}, 32'(cur_ov(wide)), 32'd1);
      e = sb.pop_front();
      check({tag, ".latency"}, 32'(n), 32'(e.lat));
      check({tag, ".d_o"}, 32'(cur_d(wide)), 32'(e.d));
      check({tag, ".in_ready_busy"}, 32'(cur_ir(wide)), 32'd0);
`ifdef GCD_ITER_COUNT_EN
      check({tag, ".iter_o"}, 32'(wide ? it16 : it8), 32'(e.lat));
`endif
   endtask

   // Complete the output handshake (out_ready already high).
   task automatic finish_job(input string tag, input bit wide, input logic [15:0] exp_d);
      @(posedge clk);
      #1;
      check({tag, ".ov_drop"}, 32'(cur_ov(wide)), 32'd0);
      check({tag, ".ir_back"}, 32'(cur_ir(wide)), 32'd1);
      check({tag, ".d_held"}, 32'(cur_d(wide)), 32'(exp_d));
   endtask

   initial begin
      // Reset state
      #12;
      check("rst.in_ready", 32'(ir8), 32'd1);
      check("rst.out_valid", 32'(ov8), 32'd0);
      check("rst.d_o", 32'(d8), 32'd0);
`ifdef GCD_ITER_COUNT_EN
      check("rst.iter_o", 32'(it8), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b1;

      run_job("j12_8", 1'b0, 16'd12, 16'd8);     finish_job("j12_8", 1'b0, 16'd4);
      check("j12_8.const", 32'(d8), 32'd4);
      run_job("j0_9", 1'b0, 16'd0, 16'd9);       finish_job("j0_9", 1'b0, 16'd9);
      run_job("j9_0", 1'b0, 16'd9, 16'd0);       finish_job("j9_0", 1'b0, 16'd9);
      run_job("j0_0", 1'b0, 16'd0, 16'd0);       finish_job("j0_0", 1'b0, 16'd0);
      run_job("j255_1", 1'b0, 16'd255, 16'd1);   finish_job("j255_1", 1'b0, 16'd1);

      // Back-pressure: result held, busy engine ignores new operands.
      @(negedge clk);
      or8 = 1'b0;
      run_job("bp21_14", 1'b0, 16'd21, 16'd14);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         iv8 = 1'b1; x8 = 8'd6; y8 = 8'd4;
         @(posedge clk);
         #1;
         check("bp.d_stable", 32'(d8), 32'd7);
         check("bp.ov_high", 32'(ov8), 32'd1);
         check("bp.ir_low", 32'(ir8), 32'd0);
      end
      @(negedge clk);
      iv8 = 1'b0;
      or8 = 1'b1;
      finish_job("bp_release", 1'b0, 16'd7);
      run_job("j6_4", 1'b0, 16'd6, 16'd4);       finish_job("j6_4", 1'b0, 16'd2);

      // Reset mid-CALC aborts the job asynchronously.
      @(negedge clk);
      iv8 = 1'b1; x8 = 8'd100; y8 = 8'd75;
      @(posedge clk);
      #1;
      iv8 = 1'b0;
      @(posedge clk);
      #1;
      check("abort.busy", 32'(ir8), 32'd0);
      reset = 1'b0;
      #1;
      check("abort.out_valid", 32'(ov8), 32'd0);
      check("abort.in_ready", 32'(ir8), 32'd1);
      check("abort.d_o", 32'(d8), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      run_job("j100_75", 1'b0, 16'd100, 16'd75); finish_job("j100_75", 1'b0, 16'd25);

      // WIDTH=16 instance
      run_job("w16_max", 1'b1, 16'd65535, 16'd65535);
      finish_job("w16_max", 1'b1, 16'd65535);
      run_job("w16_fib", 1'b1, 16'd46368, 16'd28657);
      finish_job("w16_fib", 1'b1, 16'd1);

      check("sb.empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
